// File: rtl/imply_drain.sv
// Imply-stack drain controller: pops implications, checks them against the variable
// assignment table, forwards new ones to trail/BCP and flags contradictions.
module imply_drain #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             unassign,
    input  logic [VAR_W-1:0] unassign_var,
    output logic             stk_en,
    output logic             stk_rw,
    input  logic             stk_empty,
    input  logic [VAR_W-1:0] stk_var,
    input  logic             stk_val,
    output logic             trail_push,
    output logic [VAR_W-1:0] trail_var,
    output logic             trail_val,
    output logic             bcp_valid,
    output logic [VAR_W-1:0] bcp_var,
    output logic             bcp_val,
    input  logic             bcp_ready,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic [VAR_W-1:0] conflict_var
);

    localparam int IDX_W = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_CHECK,
        S_BCP,
        S_CONFLICT
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_VARIABLE-1:0] assigned_q, assigned_d;
    logic [NUM_VARIABLE-1:0] value_q, value_d;
    logic [VAR_W-1:0]        lat_var_q, lat_var_d;
    logic                    lat_val_q, lat_val_d;
    logic [VAR_W-1:0]        out_var_q, out_var_d;
    logic                    out_val_q, out_val_d;
    logic [VAR_W-1:0]        conflict_var_q, conflict_var_d;
    logic                    stk_en_q, stk_en_d;
    logic                    trail_push_q, trail_push_d;
    logic                    bcp_valid_q, bcp_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    conflict_q, conflict_d;

    logic                    go_pop;
    logic                    lat_in_range;
    logic                    uns_in_range;
    logic [IDX_W-1:0]        lat_idx;
    logic [IDX_W-1:0]        uns_idx;

    assign lat_in_range = (lat_var_q < VAR_W'(NUM_VARIABLE));
    assign uns_in_range = (unassign_var < VAR_W'(NUM_VARIABLE));
    assign lat_idx      = lat_var_q[IDX_W-1:0];
    assign uns_idx      = unassign_var[IDX_W-1:0];

    always_comb begin
        state_d        = state_q;
        assigned_d     = assigned_q;
        value_d        = value_q;
        lat_var_d      = lat_var_q;
        lat_val_d      = lat_val_q;
        out_var_d      = out_var_q;
        out_val_d      = out_val_q;
        conflict_var_d = conflict_var_q;
        conflict_d     = conflict_q;
        bcp_valid_d    = bcp_valid_q;
        stk_en_d       = 1'b0;
        trail_push_d   = 1'b0;
        done_d         = 1'b0;
        go_pop         = 1'b0;

        // Unassign is applied first so a same-edge CHECK assignment overrides it.
        if (unassign && uns_in_range) begin
            assigned_d[uns_idx] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) go_pop = 1'b1;
            end
            S_POP: begin
                if (!stk_en_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                lat_var_d = stk_var;
                lat_val_d = stk_val;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (!lat_in_range) begin
                    go_pop = 1'b1;
                end else if (assigned_q[lat_idx]) begin
                    if (value_q[lat_idx] == lat_val_q) begin
                        go_pop = 1'b1;
                    end else begin
                        conflict_d     = 1'b1;
                        conflict_var_d = lat_var_q;
                        state_d        = S_CONFLICT;
                    end
                end else begin
                    assigned_d[lat_idx] = 1'b1;
                    value_d[lat_idx]    = lat_val_q;
                    out_var_d           = lat_var_q;
                    out_val_d           = lat_val_q;
                    trail_push_d        = 1'b1;
                    bcp_valid_d         = 1'b1;
                    state_d             = S_BCP;
                end
            end
            S_BCP: begin
                if (bcp_ready) begin
                    bcp_valid_d = 1'b0;
                    go_pop      = 1'b1;
                end
            end
            S_CONFLICT: begin
                if (start) begin
                    conflict_d = 1'b0;
                    go_pop     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // stk_en is registered, so emptiness is sampled on the edge entering POP;
        // POP then treats a deasserted stk_en as "stack was empty".
        if (go_pop) begin
            state_d  = S_POP;
            stk_en_d = !stk_empty;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_CONFLICT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            assigned_q     <= '0;
            value_q        <= '0;
            lat_var_q      <= '0;
            lat_val_q      <= 1'b0;
            out_var_q      <= '0;
            out_val_q      <= 1'b0;
            conflict_var_q <= '0;
            stk_en_q       <= 1'b0;
            trail_push_q   <= 1'b0;
            bcp_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            conflict_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            assigned_q     <= assigned_d;
            value_q        <= value_d;
            lat_var_q      <= lat_var_d;
            lat_val_q      <= lat_val_d;
            out_var_q      <= out_var_d;
            out_val_q      <= out_val_d;
            conflict_var_q <= conflict_var_d;
            stk_en_q       <= stk_en_d;
            trail_push_q   <= trail_push_d;
            bcp_valid_q    <= bcp_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            conflict_q     <= conflict_d;
        end
    end

    assign stk_en       = stk_en_q;
    assign stk_rw       = 1'b0;
    assign trail_push   = trail_push_q;
    assign trail_var    = out_var_q;
    assign trail_val    = out_val_q;
    assign bcp_valid    = bcp_valid_q;
    assign bcp_var      = out_var_q;
    assign bcp_val      = out_val_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign conflict     = conflict_q;
    assign conflict_var = conflict_var_q;

endmodule
